// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg
//   Shared definitions for the load/store unit: bus widths, access-size and
//   FSM state encodings, and the zero word.
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   -> misaligned half/word accesses return an error response
//     undefined -> low offset bits are ignored per access size
package lsu_mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef logic [DATA_W-1:0] mem_bus_t;
    typedef logic [ADDR_W-1:0] mem_addr_bus_t;
    typedef logic [SEL_W-1:0]  mem_sel_bus_t;

    localparam mem_bus_t ZeroWord = '0;

    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeIllegal = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StResp   = 2'b10
    } state_e;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MisalignTrapEn = 1'b1;
`else
    localparam bit MisalignTrapEn = 1'b0;
`endif

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_mem_ctrl_align
//   Purely combinational lane logic for one access.
//   Ports:
//     size_i      access size (byte/half/word/illegal)
//     off_i       byte offset within the word (addr[1:0])
//     wdata_i     right-aligned store data
//     rdata_i     RAM read word
//     unsigned_i  1 = zero-extend loads, 0 = sign-extend
//     sel_o       byte-lane select, bit3 = bits[31:24]
//     wdata_o     store data replicated across lanes
//     load_data_o extracted and extended load result
//     misalign_o  half with off[0]=1 or word with off!=0
//   Illegal size yields all-zero outputs.
module lsu_mem_ctrl_align
    import lsu_mem_ctrl_pkg::*;
(
    input  size_e        size_i,
    input  logic [1:0]   off_i,
    input  mem_bus_t     wdata_i,
    input  mem_bus_t     rdata_i,
    input  logic         unsigned_i,
    output mem_sel_bus_t sel_o,
    output mem_bus_t     wdata_o,
    output mem_bus_t     load_data_o,
    output logic         misalign_o
);

    mem_bus_t byte_sh;
    mem_bus_t half_sh;

    // Bring the addressed byte/half down to bit 0 before extending.
    assign byte_sh = rdata_i >> {off_i, 3'b000};
    assign half_sh = rdata_i >> {off_i[1], 4'b0000};

    always_comb begin
        sel_o       = '0;
        wdata_o     = ZeroWord;
        load_data_o = ZeroWord;
        misalign_o  = 1'b0;
        case (size_i)
            SizeByte: begin
                sel_o       = 4'b0001 << off_i;
                wdata_o     = {4{wdata_i[7:0]}};
                load_data_o = {{24{~unsigned_i & byte_sh[7]}}, byte_sh[7:0]};
            end
            SizeHalf: begin
                sel_o       = 4'b0011 << {off_i[1], 1'b0};
                wdata_o     = {2{wdata_i[15:0]}};
                load_data_o = {{16{~unsigned_i & half_sh[15]}}, half_sh[15:0]};
                misalign_o  = off_i[0];
            end
            SizeWord: begin
                sel_o       = 4'b1111;
                wdata_o     = wdata_i;
                load_data_o = rdata_i;
                misalign_o  = |off_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl
//   Load/store unit in front of the data RAM. One request per handshake,
//   three-state FSM IDLE -> ACCESS -> RESP. The RAM is driven only during
//   ACCESS; load data and the error flag register on the edge leaving ACCESS
//   and are presented on the response channel until resp_ready.
//   Optional feature macro: LSU_MISALIGN_TRAP_EN (see lsu_mem_ctrl_pkg).
//   Ports:
//     clk, rst                        clock; asynchronous active-low reset
//     req_valid/req_ready             request handshake
//     req_we/size/unsigned/addr/wdata request fields
//     resp_valid/resp_ready           response handshake
//     resp_rdata/resp_err             extended load data / error flag
//     mem_we/sel/addr/wdata           RAM controls (zero outside ACCESS)
//     mem_rdata                       combinational RAM read word
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  mem_addr_bus_t req_addr,
    input  mem_bus_t      req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output mem_bus_t      resp_rdata,
    output logic          resp_err,
    output logic          mem_we,
    output mem_sel_bus_t  mem_sel,
    output mem_addr_bus_t mem_addr,
    output mem_bus_t      mem_wdata,
    input  mem_bus_t      mem_rdata
);

    state_e        state_q, state_d;
    logic          we_q;
    size_e         size_q;
    logic          uns_q;
    mem_addr_bus_t addr_q;
    mem_bus_t      wdata_q;
    mem_bus_t      rdata_q;
    logic          err_q;

    mem_sel_bus_t  lane_sel;
    mem_bus_t      lane_wdata;
    mem_bus_t      load_data;
    logic          misalign;
    logic          err;

    lsu_mem_ctrl_align u_align (
        .size_i      (size_q),
        .off_i       (addr_q[1:0]),
        .wdata_i     (wdata_q),
        .rdata_i     (mem_rdata),
        .unsigned_i  (uns_q),
        .sel_o       (lane_sel),
        .wdata_o     (lane_wdata),
        .load_data_o (load_data),
        .misalign_o  (misalign)
    );

    assign err = (size_q == SizeIllegal) | (misalign & MisalignTrapEn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= SizeByte;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= ZeroWord;
            rdata_q <= ZeroWord;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                we_q    <= req_we;
                size_q  <= size_e'(req_size);
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // Load result is sampled from the RAM on the edge leaving ACCESS.
            if (state_q == StAccess) begin
                rdata_q <= (we_q | err) ? ZeroWord : load_data;
                err_q   <= err;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = ZeroWord;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_sel    = '0;
        mem_addr   = '0;
        mem_wdata  = ZeroWord;
        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) state_d = StAccess;
            end
            StAccess: begin
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_sel   = err ? '0 : lane_sel;
                mem_we    = we_q & ~err;
                mem_wdata = (we_q & ~err) ? lane_wdata : ZeroWord;
                state_d   = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
